// File: rtl/line_pkg.sv
// Shared definitions for the filler/sealer line supervisor and the station top.
// State codes are plain 3-bit constants so they can be compared directly
// against the fault_ph_o / state_o buses by anything bound to this block.
package line_pkg;

    // Supervisor state codes (IDLE=0 .. FAULT=7)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_REQ_FILL  = 3'd1;
    localparam logic [2:0] ST_WAIT_FILL = 3'd2;
    localparam logic [2:0] ST_WAIT_SEAL = 3'd3;
    localparam logic [2:0] ST_INSPECT   = 3'd4;
    localparam logic [2:0] ST_RELEASE   = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;
    localparam logic [2:0] ST_FAULT     = 3'd7;

    typedef logic [2:0] state_t;

    // Bit positions inside the station status bus
    localparam int LLENANDO  = 0;
    localparam int SELLANDO  = 1;
    localparam int SEAL_DONE = 2;
    localparam int STATUS_W  = 3;

    // Width of the per-state phase timers
    localparam int TMR_W = 16;

    // States in which a batch is actively being worked on
    function automatic logic is_busy_state(input state_t st);
        return (st == ST_REQ_FILL)  || (st == ST_WAIT_FILL) ||
               (st == ST_WAIT_SEAL) || (st == ST_INSPECT)   ||
               (st == ST_RELEASE);
    endfunction

    // States that wait on the station and are therefore guarded by the timeout
    function automatic logic is_timed_state(input state_t st);
        return (st == ST_REQ_FILL)  || (st == ST_WAIT_FILL) ||
               (st == ST_WAIT_SEAL) || (st == ST_RELEASE);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating cycle counter used to measure how long the supervisor has sat in
// a state. clear_i has priority; expired_o is high once LIMIT cycles have been
// counted and stays high (the count stops) until the next clear.
module phase_timer
    import line_pkg::*;
#(
    parameter int          W     = TMR_W,
    parameter int unsigned LIMIT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired_o = (count_q >= LIMIT_V);

    // Next count: clear wins, otherwise count up until the limit is reached
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/line_supervisor_fsm.sv
// Batch supervisor for the filler/sealer station pair.
// Sequences fill -> seal -> inspect -> release for each product of a batch,
// counts completed units and raises a sticky fault if the station stalls in
// any waiting phase for TIMEOUT_CYC cycles. All outputs are registered from
// the next-state value, so every output changes one clock after the input
// that caused it was sampled.
//
// Station handshake: startfill_o is held until the filler reports llenando_i;
// productook_o is held until the sealer drops sellando_i. Each command is a
// level that the station acknowledges with a status level, never a pulse.
module line_supervisor_fsm
    import line_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int INSPECT_CYC = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             abort_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] batch_size_i,
    input  logic             llenando_i,
    input  logic             sellando_i,
    input  logic             seal_done_i,
    output logic             startfill_o,
    output logic             productook_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fault_o,
    output logic [2:0]       fault_ph_o,
    output logic [CNT_W-1:0] units_o,
    output logic [2:0]       state_o
);

    // INSPECT lasts INSPECT_CYC cycles: the timer expires after INSPECT_CYC-1
    // counts because the entry cycle itself is the first inspect cycle.
    localparam int unsigned INSP_LIMIT = (INSPECT_CYC > 1) ? INSPECT_CYC - 1 : 0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] size_q, size_d;
    logic [CNT_W-1:0] units_q, units_d;
    logic [CNT_W-1:0] units_inc;
    logic [2:0]       fault_ph_q, fault_ph_d;
    logic             startfill_q, startfill_d;
    logic             productook_q, productook_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic [STATUS_W-1:0] status;
    logic                state_change;
    logic                tmo_expired;
    logic                insp_expired;

    // Gather station status into the shared bus layout
    always_comb begin
        status            = '0;
        status[LLENANDO]  = llenando_i;
        status[SELLANDO]  = sellando_i;
        status[SEAL_DONE] = seal_done_i;
    end

    assign state_change = (state_d != state_q);
    assign units_inc    = units_q + CNT_W'(1);

    // Watchdog for the station-facing wait states
    phase_timer #(
        .W     (TMR_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_change),
        .enable_i  (is_timed_state(state_q)),
        .expired_o (tmo_expired)
    );

    // Fixed inspection delay between seal completion and product release
    phase_timer #(
        .W     (TMR_W),
        .LIMIT (INSP_LIMIT)
    ) u_inspect (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_change),
        .enable_i  (state_q == ST_INSPECT),
        .expired_o (insp_expired)
    );

    // Next-state logic; in every wait state the order is abort, then
    // progress, then timeout, so a late station response still counts.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        units_d    = units_q;
        fault_ph_d = fault_ph_q;

        case (state_q)
            ST_IDLE: begin
                if (run_i && (batch_size_i != '0)) begin
                    size_d  = batch_size_i;
                    units_d = '0;
                    state_d = ST_REQ_FILL;
                end
            end

            ST_REQ_FILL: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (status[LLENANDO]) begin
                    state_d = ST_WAIT_FILL;
                end else if (tmo_expired) begin
                    state_d    = ST_FAULT;
                    fault_ph_d = ST_REQ_FILL;
                end
            end

            ST_WAIT_FILL: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (status[SELLANDO]) begin
                    state_d = ST_WAIT_SEAL;
                end else if (tmo_expired) begin
                    state_d    = ST_FAULT;
                    fault_ph_d = ST_WAIT_FILL;
                end
            end

            ST_WAIT_SEAL: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (status[SEAL_DONE]) begin
                    state_d = ST_INSPECT;
                end else if (tmo_expired) begin
                    state_d    = ST_FAULT;
                    fault_ph_d = ST_WAIT_SEAL;
                end
            end

            ST_INSPECT: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (insp_expired) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (!status[SELLANDO]) begin
                    units_d = units_inc;
                    state_d = (units_inc == size_q) ? ST_DONE : ST_REQ_FILL;
                end else if (tmo_expired) begin
                    state_d    = ST_FAULT;
                    fault_ph_d = ST_RELEASE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_FAULT: begin
                if (clear_i) begin
                    state_d    = ST_IDLE;
                    fault_ph_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register with it
    always_comb begin
        startfill_d  = (state_d == ST_REQ_FILL);
        productook_d = (state_d == ST_RELEASE);
        busy_d       = is_busy_state(state_d);
        done_d       = (state_d == ST_DONE);
        fault_d      = (state_d == ST_FAULT);
    end

    // State, batch bookkeeping and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            size_q       <= '0;
            units_q      <= '0;
            fault_ph_q   <= '0;
            startfill_q  <= 1'b0;
            productook_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            units_q      <= units_d;
            fault_ph_q   <= fault_ph_d;
            startfill_q  <= startfill_d;
            productook_q <= productook_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    assign startfill_o  = startfill_q;
    assign productook_o = productook_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fault_o      = fault_q;
    assign fault_ph_o   = fault_ph_q;
    assign units_o      = units_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_line_supervisor_fsm.sv
// Bench for line_supervisor_fsm: directed batches against a small station
// model, with an event scoreboard (units change, done pulse, startfill rise,
// fault rise) plus point checks at the cycle-exact moments of interest.
module tb_line_supervisor_fsm;

    localparam int T_CYC = 40;
    localparam int I_CYC = 4;
    localparam int CW    = 8;
    localparam int W     = 16;

    localparam logic [3:0] EV_UNITS = 4'd1;
    localparam logic [3:0] EV_DONE  = 4'd2;
    localparam logic [3:0] EV_FILL  = 4'd3;
    localparam logic [3:0] EV_FAULT = 4'd4;

    logic          clk;
    logic          rst_n;
    logic          run_i;
    logic          abort_i;
    logic          clear_i;
    logic [CW-1:0] batch_size_i;
    logic          llenando_i;
    logic          sellando_i;
    logic          seal_done_i;
    logic          startfill_o;
    logic          productook_o;
    logic          busy_o;
    logic          done_o;
    logic          fault_o;
    logic [2:0]    fault_ph_o;
    logic [CW-1:0] units_o;
    logic [2:0]    state_o;

    logic [W-1:0] exp_q[$];
    int           checks;
    int           failures;

    // station model controls
    logic model_en;
    logic stuck_sell;
    int   m_ph;
    int   m_cnt;

    line_supervisor_fsm #(
        .TIMEOUT_CYC (T_CYC),
        .INSPECT_CYC (I_CYC),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run_i),
        .abort_i      (abort_i),
        .clear_i      (clear_i),
        .batch_size_i (batch_size_i),
        .llenando_i   (llenando_i),
        .sellando_i   (sellando_i),
        .seal_done_i  (seal_done_i),
        .startfill_o  (startfill_o),
        .productook_o (productook_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fault_o      (fault_o),
        .fault_ph_o   (fault_ph_o),
        .units_o      (units_o),
        .state_o      (state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [11:0] p);
        return {k, p};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic got_event(input logic [W-1:0] got);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected: got=%h expected=none (t=%0t)", got, $time);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL event_order: got=%h expected=%h (t=%0t)", got, exp, $time);
            end
        end
    endtask

    task automatic push_ev(input logic [3:0] k, input logic [11:0] p);
        exp_q.push_back(ev(k, p));
    endtask

    // wait (bounded) for a given state and unit count
    task automatic wait_state(input logic [2:0] st, input logic [CW-1:0] u,
                              input int budget, input string name);
        int n;
        n = 0;
        while (!(state_o == st && units_o == u) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state_o != st || units_o != u) begin
            failures++;
            $display("FAIL %s: state=%0d units=%0d expected state=%0d units=%0d within %0d cycles",
                     name, state_o, units_o, st, u, budget);
        end
    endtask

    // wait (bounded) for a high level on done_o (sel=0) or fault_o (sel=1)
    task automatic wait_flag(input int sel, input int budget, input string name);
        int n;
        logic f;
        n = 0;
        f = (sel == 0) ? done_o : fault_o;
        while (!f && n < budget) begin
            @(negedge clk);
            n++;
            f = (sel == 0) ? done_o : fault_o;
        end
        check(name, 32'(f), 32'd1);
    endtask

    task automatic run_batch(input logic [CW-1:0] size);
        @(negedge clk);
        run_i        = 1'b1;
        batch_size_i = size;
        @(negedge clk);
        run_i        = 1'b0;
    endtask

    task automatic station_off();
        model_en   = 1'b0;
        stuck_sell = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus, station model, monitor ----------------
    initial begin
        logic pu_valid;
        logic [CW-1:0] pu;
        logic pd, ps, pf;

        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        run_i        = 1'b0;
        abort_i      = 1'b0;
        clear_i      = 1'b0;
        batch_size_i = '0;
        llenando_i   = 1'b0;
        sellando_i   = 1'b0;
        seal_done_i  = 1'b0;
        model_en     = 1'b0;
        stuck_sell   = 1'b0;
        m_ph         = 0;
        m_cnt        = 0;
        pu_valid     = 1'b0;
        pu = '0; pd = 1'b0; ps = 1'b0; pf = 1'b0;

        fork
            // station model: fill after startfill, seal, pulse seal_done,
            // then drop sellando once productook is seen (unless stuck)
            forever begin
                @(negedge clk);
                if (!model_en) begin
                    m_ph = 0; m_cnt = 0;
                    llenando_i = 1'b0; sellando_i = 1'b0; seal_done_i = 1'b0;
                end else begin
                    case (m_ph)
                        0: if (startfill_o) begin
                            m_cnt++;
                            if (m_cnt == 2) begin llenando_i = 1'b1; m_cnt = 0; m_ph = 1; end
                        end
                        1: begin
                            m_cnt++;
                            if (m_cnt == 3) begin
                                llenando_i = 1'b0; sellando_i = 1'b1; m_cnt = 0; m_ph = 2;
                            end
                        end
                        2: begin
                            m_cnt++;
                            if (m_cnt == 3) begin seal_done_i = 1'b1; m_cnt = 0; m_ph = 3; end
                        end
                        default: begin
                            seal_done_i = 1'b0;
                            if (productook_o) begin
                                if (!stuck_sell) sellando_i = 1'b0;
                                m_ph = 0;
                            end
                        end
                    endcase
                end
            end

            // monitor: turn output edges into events and score them
            forever begin
                @(negedge clk);
                if (!rst_n || !pu_valid) begin
                    pu_valid = rst_n;
                end else begin
                    if (units_o !== pu)        got_event(ev(EV_UNITS, {4'b0, units_o}));
                    if (done_o && !pd)         got_event(ev(EV_DONE, {4'b0, units_o}));
                    if (startfill_o && !ps)    got_event(ev(EV_FILL, {4'b0, units_o}));
                    if (fault_o && !pf)        got_event(ev(EV_FAULT, {9'b0, fault_ph_o}));
                end
                pu = units_o; pd = done_o; ps = startfill_o; pf = fault_o;
            end
        join_none

        // ---- reset state ----
        #1;
        check("rst_startfill", 32'(startfill_o), 0);
        check("rst_productook", 32'(productook_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_fault", 32'(fault_o), 0);
        check("rst_fault_ph", 32'(fault_ph_o), 0);
        check("rst_units", 32'(units_o), 0);
        check("rst_state", 32'(state_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- 1: batch of 3 with a well-behaved station ----
        push_ev(EV_FILL, 0);  push_ev(EV_UNITS, 1);
        push_ev(EV_FILL, 1);  push_ev(EV_UNITS, 2);
        push_ev(EV_FILL, 2);  push_ev(EV_UNITS, 3);
        push_ev(EV_DONE, 3);
        model_en = 1'b1;
        run_batch(3);
        check("t1_busy_after_run", 32'(busy_o), 1);
        check("t1_startfill_after_run", 32'(startfill_o), 1);
        wait_flag(0, 300, "t1_done_seen");
        check("t1_units_at_done", 32'(units_o), 3);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(done_o), 0);
        check("t1_back_idle", 32'(state_o), 0);
        check("t1_busy_low", 32'(busy_o), 0);
        station_off();

        // ---- 2: run with batch size 0 is ignored ----
        run_batch(0);
        for (int i = 0; i < 4; i++) begin
            check("t2_busy_low", 32'(busy_o), 0);
            check("t2_no_startfill", 32'(startfill_o), 0);
            @(negedge clk);
        end
        check("t2_units_kept", 32'(units_o), 3);

        // ---- 3: filler never answers -> timeout in REQ_FILL ----
        push_ev(EV_UNITS, 0);
        push_ev(EV_FILL, 0);
        push_ev(EV_FAULT, 1);
        run_batch(3);
        repeat (T_CYC) @(negedge clk);
        check("t3_no_fault_yet", 32'(fault_o), 0);
        check("t3_startfill_held", 32'(startfill_o), 1);
        @(negedge clk);
        check("t3_fault_at_limit", 32'(fault_o), 1);
        check("t3_fault_ph", 32'(fault_ph_o), 1);
        check("t3_startfill_dropped", 32'(startfill_o), 0);
        check("t3_busy_low", 32'(busy_o), 0);
        run_batch(2);
        check("t3_run_ignored_in_fault", 32'(state_o), 7);
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("t3_cleared_fault", 32'(fault_o), 0);
        check("t3_cleared_idle", 32'(state_o), 0);

        // ---- 4: sealer stuck in RELEASE -> timeout in RELEASE ----
        push_ev(EV_FILL, 0);
        push_ev(EV_FAULT, 5);
        model_en   = 1'b1;
        stuck_sell = 1'b1;
        run_batch(2);
        wait_state(3'd5, 0, 100, "t4_reach_release");
        check("t4_productook_high", 32'(productook_o), 1);
        wait_flag(1, 200, "t4_fault_seen");
        check("t4_fault_ph", 32'(fault_ph_o), 5);
        check("t4_productook_dropped", 32'(productook_o), 0);
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("t4_cleared_idle", 32'(state_o), 0);
        station_off();

        // ---- 5: abort in WAIT_SEAL of unit 2 ----
        push_ev(EV_FILL, 0); push_ev(EV_UNITS, 1);
        push_ev(EV_FILL, 1);
        model_en = 1'b1;
        run_batch(3);
        wait_state(3'd3, 1, 200, "t5_reach_wait_seal_u2");
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("t5_abort_idle", 32'(state_o), 0);
        check("t5_units_held", 32'(units_o), 1);
        check("t5_startfill_low", 32'(startfill_o), 0);
        check("t5_productook_low", 32'(productook_o), 0);
        check("t5_busy_low", 32'(busy_o), 0);
        station_off();

        // ---- 6: async reset in the middle of RELEASE ----
        push_ev(EV_UNITS, 0);
        push_ev(EV_FILL, 0);
        model_en   = 1'b1;
        stuck_sell = 1'b1;
        run_batch(2);
        wait_state(3'd5, 0, 100, "t6_reach_release");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_productook", 32'(productook_o), 0);
        check("t6_rst_units", 32'(units_o), 0);
        check("t6_rst_state", 32'(state_o), 0);
        check("t6_rst_busy", 32'(busy_o), 0);
        model_en   = 1'b0;
        stuck_sell = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_after_reset", 32'(state_o), 0);

        // every expected event must have been observed
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard stop in case something stalls outside a bounded wait
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
